// File: rtl/seg7_pkg.sv
// Shared segment encodings for the seven-segment scan controller.
// Bit order of every code is {a,b,c,d,e,f,g,dp}; a set bit lights the segment.
package seg7_pkg;

  localparam int         SEG_DP_BIT = 0;
  localparam logic [7:0] SEG_BLANK  = 8'h00;

  localparam logic [7:0] SEG_CODES [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  function automatic logic is_bcd(input logic [3:0] value);
    return value < 4'd10;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder with decimal-point merge.
// Values 10-15 decode to blank unless hex_mode is set.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_mode,
  input  logic       dp,
  output logic [7:0] code
);

  always_comb begin
    // NOTE: default first so every path assigns code and no latch is inferred.
    code = SEG_BLANK;
    if (hex_mode || is_bcd(value)) code = SEG_CODES[value];
    code[SEG_DP_BIT] = code[SEG_DP_BIT] | dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment driver for two segment banks with frame-coherent
// input snapshots, blanking (enable, blink, leading zeros) and registered outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int BANK_DIGITS = NUM_DIGITS / 2,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_LOG2  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              segout_0,
  output logic [7:0]              segout_1,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    hex_mode;
    logic                    lz_suppress;
  } snap_t;

  logic [PRE_W-1:0]      prescaler;
  logic [IDX_W-1:0]      idx;
  snap_t                 snap;
  logic [BLINK_LOG2-1:0] blink_cnt;
  logic                  blink_phase;
  logic                  first;

  logic       pre_tc;
  logic       idx_last;
  logic       load;
  logic [3:0] cur_value;
  logic       upper_zero;
  logic       blank;
  logic       in_bank0;
  logic [7:0] dec_code;
  logic [7:0] code;

  assign pre_tc   = prescaler == PRE_W'(SCAN_DIV - 1);
  assign idx_last = idx == IDX_W'(NUM_DIGITS - 1);
  assign load     = first | (pre_tc & idx_last);

  // The prescaler idles during the initial load so digit 0 gets a full slot in frame 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      idx         <= '0;
      snap        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      first       <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere so every register samples pre-edge values.
      first <= 1'b0;
      if (!first) begin
        prescaler <= pre_tc ? '0 : prescaler + 1'b1;
        if (pre_tc) idx <= idx_last ? '0 : idx + 1'b1;
      end
      if (load) begin
        snap        <= '{digits, dp_en, digit_en, blink_mask, hex_mode, lz_suppress};
        blink_cnt   <= blink_cnt + 1'b1;
        if (&blink_cnt) blink_phase <= ~blink_phase;
      end
    end
  end

  assign cur_value  = snap.digits[{idx, 2'b00} +: 4];
  assign upper_zero = (snap.digits >> {idx, 2'b00}) == '0;
  assign in_bank0   = idx < IDX_W'(BANK_DIGITS);

  seg7_decoder u_decoder (
    .value    (cur_value),
    .hex_mode (snap.hex_mode),
    .dp       (snap.dp_en[idx]),
    .code     (dec_code)
  );

  always_comb begin
    blank = !snap.digit_en[idx]
          | (snap.blink_mask[idx] & blink_phase)
          | (snap.lz_suppress & upper_zero & (idx != '0));
    code  = blank ? SEG_BLANK : dec_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '0;
      segout_0   <= SEG_BLANK;
      segout_1   <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      an         <= snap.digit_en[idx] ? NUM_DIGITS'(1) << idx : '0;
      segout_0   <= in_bank0 ? code : SEG_BLANK;
      segout_1   <= in_bank0 ? SEG_BLANK : code;
      frame_tick <= load;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: scheduled and random input patterns, changed mid-frame,
// compared every cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_ctrl;

  localparam int ND    = 8;
  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = ND * SD;
  localparam int NF    = 20;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [7:0]  bm;
    logic        hex;
    logic        lz;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   digits;
  logic [ND-1:0] dp_en;
  logic [ND-1:0] digit_en;
  logic          hex_mode;
  logic          lz_suppress;
  logic [ND-1:0] blink_mask;
  logic [ND-1:0] an;
  logic [7:0]    segout_0;
  logic [7:0]    segout_1;
  logic          frame_tick;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    e        = 0;
  int    change_edge = -1;
  int    pat_no   = 0;
  snap_t snaps[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_LOG2 (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .dp_en       (dp_en),
    .digit_en    (digit_en),
    .hex_mode    (hex_mode),
    .lz_suppress (lz_suppress),
    .blink_mask  (blink_mask),
    .an          (an),
    .segout_0    (segout_0),
    .segout_1    (segout_1),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int v);
    case (v)
      0: return 8'hFC;   1: return 8'h60;   2: return 8'hDA;   3: return 8'hF2;
      4: return 8'h66;   5: return 8'hB6;   6: return 8'hBE;   7: return 8'hE0;
      8: return 8'hFE;   9: return 8'hF6;   10: return 8'hEE;  11: return 8'h3E;
      12: return 8'h9C;  13: return 8'h7A;  14: return 8'h9E;  15: return 8'h8E;
      default: return 8'h00;
    endcase
  endfunction

  // Expected display for slot d of frame k, given that frame's captured inputs.
  function automatic void ref_out(input snap_t s, input int k, input int d,
                                  output logic [7:0] a, output logic [7:0] s0,
                                  output logic [7:0] s1);
    logic [7:0] c;
    logic       phase;
    logic       blank;
    int         v;
    v     = int'((s.digits >> (4 * d)) & 32'hF);
    phase = (((k + 1) >> BL) & 1) != 0;
    blank = !s.en[d] || (s.bm[d] && phase) ||
            (s.lz && d != 0 && (s.digits >> (4 * d)) == 32'h0);
    c     = (v < 10 || s.hex) ? ref_seg(v) : 8'h00;
    c[0]  = c[0] | s.dp[d];
    if (blank) c = 8'h00;
    a  = s.en[d] ? 8'(1 << d) : 8'h00;
    s0 = (d < ND / 2) ? c : 8'h00;
    s1 = (d < ND / 2) ? 8'h00 : c;
  endfunction

  task automatic apply_pattern(input int p);
    digits = 32'h76543210; dp_en = '0; digit_en = '1;
    hex_mode = 1'b0; lz_suppress = 1'b0; blink_mask = '0;
    case (p)
      0: ;
      1: begin digits = 32'hFEDCBA98; hex_mode = 1'b1; end
      2: digits = 32'hFEDCBA98;
      3: begin digits = 32'h00000305; lz_suppress = 1'b1; end
      4: begin digits = 32'h00000000; lz_suppress = 1'b1; end
      5, 6, 7, 8: begin blink_mask = 8'h01; dp_en = 8'h01; end
      default: begin
        digits      = $urandom >> (4 * $urandom_range(0, 7));
        dp_en       = 8'($urandom);
        digit_en    = 8'($urandom) | 8'($urandom);
        blink_mask  = 8'($urandom);
        hex_mode    = 1'($urandom);
        lz_suppress = 1'($urandom);
      end
    endcase
  endtask

  task automatic run_edges(input int n);
    logic [7:0] ea, es0, es1;
    logic       eft;
    int         t;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      e++;
      eft = ((e - 1) % FRAME) == 0;
      if (eft) begin
        snaps.push_back('{digits, dp_en, digit_en, blink_mask, hex_mode, lz_suppress});
        if (change_edge >= 0) change_edge = e + $urandom_range(0, FRAME - 1);
      end
      @(negedge clk);
      if (e == 1) begin
        ea = 8'h00; es0 = 8'h00; es1 = 8'h00;
      end else begin
        t = e - 2;
        ref_out(snaps[t / FRAME], t / FRAME, (t % FRAME) / SD, ea, es0, es1);
      end
      check($sformatf("an@%0d", e), an, ea);
      check($sformatf("seg0@%0d", e), segout_0, es0);
      check($sformatf("seg1@%0d", e), segout_1, es1);
      check($sformatf("tick@%0d", e), 8'(frame_tick), 8'(eft));
      if (e == change_edge) begin
        pat_no++;
        apply_pattern(pat_no);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    apply_pattern(0);
    repeat (3) @(negedge clk);
    check("rst_an", an, 8'h00);
    check("rst_seg0", segout_0, 8'h00);
    check("rst_seg1", segout_1, 8'h00);
    check("rst_tick", 8'(frame_tick), 8'h00);
    rst_n = 1'b1;
    change_edge = 0;
    run_edges(NF * FRAME);

    // Freeze on the plain pattern so a lit digit is showing when reset hits.
    change_edge = -1;
    apply_pattern(0);
    run_edges(FRAME + FRAME / 2 + 1);
    check("an_live", 8'(an != '0), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", an, 8'h00);
    check("async_seg0", segout_0, 8'h00);
    check("async_seg1", segout_1, 8'h00);
    check("async_tick", 8'(frame_tick), 8'h00);
    repeat (2) @(negedge clk);
    check("hold_an", an, 8'h00);

    rst_n = 1'b1;
    e = 0;
    snaps.delete();
    change_edge = 0;
    run_edges(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
